// File: rtl/ex_result_sequencer_if.sv
// Signal bundle between the execute unit / MA stage and the EX result sequencer.
// The master drives EX and MA status; the slave (the sequencer) returns hold and the EX/MA register.
interface ex_result_sequencer_if;
  logic        s_valid_i;
  logic        s_multi_i;
  logic        s_finished_i;
  logic [31:0] s_result_i;
  logic        s_stall_i;
  logic        s_flush_i;
  logic        s_ex_hold_o;
  logic        s_busy_o;
  logic        s_ma_valid_o;
  logic [31:0] s_ma_result_o;
  logic        s_timeout_o;

  modport master (
    output s_valid_i, s_multi_i, s_finished_i, s_result_i, s_stall_i, s_flush_i,
    input  s_ex_hold_o, s_busy_o, s_ma_valid_o, s_ma_result_o, s_timeout_o
  );

  modport slave (
    input  s_valid_i, s_multi_i, s_finished_i, s_result_i, s_stall_i, s_flush_i,
    output s_ex_hold_o, s_busy_o, s_ma_valid_o, s_ma_result_o, s_timeout_o
  );
endinterface

// File: rtl/ex_result_sequencer.sv
// Decides each cycle whether the EX instruction retires into the EX/MA register, holding EX
// during multi-cycle MDU/CMU operations, buffering results across MA stalls, and watchdogging WAIT.
module ex_result_sequencer #(
  parameter int TIMEOUT = 64
) (
  input logic                  s_clk_i,
  input logic                  s_reset_i,
  ex_result_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      buf_q, buf_d;
  logic             ma_valid_q, ma_valid_d;
  logic [31:0]      ma_result_q, ma_result_d;
  logic             timeout_q, timeout_d;

  logic        fin;
  logic        capture;
  logic [31:0] cap_src;

  // A finish flag only means something for a valid multi-cycle instruction.
  assign fin = bus.s_valid_i & bus.s_multi_i & bus.s_finished_i;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_d     = state_q;
    cnt_d       = '0;
    buf_d       = buf_q;
    timeout_d   = 1'b0;
    capture     = 1'b0;
    cap_src     = bus.s_result_i;
    ma_valid_d  = ma_valid_q;
    ma_result_d = ma_result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.s_valid_i && !bus.s_multi_i) begin
          capture = !bus.s_stall_i;
        end else if (bus.s_valid_i && bus.s_multi_i) begin
          if (fin && !bus.s_stall_i) begin
            capture = 1'b1;
          end else if (fin) begin
            buf_d   = bus.s_result_i;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (fin && !bus.s_stall_i) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end else if (fin) begin
          buf_d   = bus.s_result_i;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (!bus.s_stall_i) begin
          capture = 1'b1;
          cap_src = buf_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Capture only ever happens unstalled; an unstalled cycle without one is a bubble.
    if (!bus.s_stall_i) begin
      ma_valid_d = capture;
      if (capture) ma_result_d = cap_src;
    end

    // Flush kills whatever this cycle would have retired or timed out.
    if (bus.s_flush_i) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      timeout_d   = 1'b0;
      ma_valid_d  = 1'b0;
      ma_result_d = ma_result_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      // NOTE: the result buffer is a plain register, so it is reset to drop any pending result.
      buf_q       <= '0;
      ma_valid_q  <= 1'b0;
      ma_result_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      ma_valid_q  <= ma_valid_d;
      ma_result_q <= ma_result_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    bus.s_ex_hold_o = 1'b0;
    if (!bus.s_flush_i) begin
      bus.s_ex_hold_o = bus.s_stall_i
                      || (state_q == ST_DONE)
                      || ((state_q == ST_WAIT) && !fin)
                      || ((state_q == ST_IDLE) && bus.s_valid_i && bus.s_multi_i && !fin);
    end
  end

  assign bus.s_busy_o      = (state_q != ST_IDLE);
  assign bus.s_ma_valid_o  = ma_valid_q;
  assign bus.s_ma_result_o = ma_result_q;
  assign bus.s_timeout_o   = timeout_q;
endmodule

// File: doc/ex_result_sequencer.md
# ex_result_sequencer

EX-stage result sequencer for the execute unit. It takes the execute unit's result and completion flag and decides, each cycle, whether the EX instruction retires into the EX/MA pipeline register. It holds the EX stage while a multi-cycle MDU/CMU operation runs, and buffers a finished result while MA is stalled. It obeys MA-stage stall and flush, and watchdogs multi-cycle operations that never complete.

## Interface
- TIMEOUT, 64, maximum cycles a multi-cycle operation may stay in WAIT; must be ≥ 2
- s_clk_i  input  1  clock
- s_reset_i  input  1  synchronous reset, active-high
- s_valid_i  input  1  EX stage holds a valid instruction
- s_multi_i  input  1  EX instruction targets a multi-cycle unit (MDU or CMU)
- s_finished_i  input  1  execute unit completion flag; ignored unless s_valid_i & s_multi_i
- s_result_i  input  32  execute unit result
- s_stall_i  input  1  MA stage stall
- s_flush_i  input  1  MA stage flush (kills EX)
- s_ex_hold_o  output  1  hold EX operands/control stable; upstream must not advance
- s_busy_o  output  1  FSM is in WAIT or DONE
- s_ma_valid_o  output  1  EX/MA register holds a valid result
- s_ma_result_o  output  32  EX/MA result register
- s_timeout_o  output  1  one-cycle pulse: watchdog expired, EX instruction dropped

## Operation
- States: IDLE, WAIT, DONE. Internal registers: 32-bit buffer, counter of width $clog2(TIMEOUT).
- "Capture" means: on the next edge, s_ma_result_o ← source and s_ma_valid_o ← 1.

**IDLE**
- Not stalled, s_valid_i, !s_multi_i: capture s_result_i.
- s_valid_i & s_multi_i & s_finished_i & !s_stall_i: capture s_result_i; stay in IDLE.
- s_valid_i & s_multi_i & !s_finished_i: go to WAIT; counter ← 1.
- s_valid_i & s_multi_i & s_finished_i & s_stall_i: buffer ← s_result_i; go to DONE.

**WAIT**
- Counter increments every cycle, saturating at TIMEOUT-1.
- s_finished_i & !s_stall_i: capture s_result_i; go to IDLE.
- s_finished_i & s_stall_i: buffer ← s_result_i; go to DONE.
- Counter == TIMEOUT-1 and !s_finished_i: s_timeout_o = 1 for the next cycle only; go to IDLE; nothing is captured.
- If s_finished_i is asserted in the same cycle, finish takes priority over the timeout.

**DONE**
- !s_stall_i: capture the buffer; go to IDLE.

**Any state**
- !s_stall_i and no capture this cycle: s_ma_valid_o ← 0 (bubble).
- s_stall_i: s_ma_valid_o and s_ma_result_o hold.

**Flush** (highest priority, below reset)
- Next state IDLE, counter ← 0, s_ma_valid_o ← 0, no capture, no timeout pulse.
- A flush in the same cycle as a finish or timeout discards it.

**s_ex_hold_o** (combinational)
- Asserted when: s_stall_i, OR state==DONE, OR state==WAIT & !s_finished_i, OR (IDLE & s_valid_i & s_multi_i & !s_finished_i).
- Forced to 0 when s_flush_i is asserted.

**s_busy_o** = state != IDLE.

## Timing
- **Reset:** state IDLE, counter 0, buffer 0. s_ma_valid_o=0, s_ma_result_o=0, s_timeout_o=0, s_busy_o=0. s_ex_hold_o follows its combinational equation from inputs.
- **Single-cycle op:** result visible on s_ma_result_o one cycle after the EX cycle.
- **Multi-cycle op** with finish in cycle N after entering EX (no stall): hold asserted cycles 0..N-1; result registered at edge N+1.
- **Stall release from DONE:** result appears one cycle after s_stall_i falls.
- **Watchdog:** s_timeout_o pulses in cycle TIMEOUT after the WAIT entry edge.
- Reset mid-operation aborts any pending buffer or count.
- s_finished_i, s_stall_i and s_flush_i are all sampled on the same edge.
- No combinational path from s_result_i to any output.

## Test plan
- **Reset, then ALU op:** s_valid_i=1, s_multi_i=0, s_result_i=0x0000_00A5, no stall → next cycle s_ma_valid_o=1, s_ma_result_o=0xA5; s_ex_hold_o=0 throughout.
- **Multi-cycle, finish at cycle 4:** s_multi_i=1, s_finished_i rises in cycle 4 with result 0x1234_5678 → s_ex_hold_o=1 in cycles 0-3, s_busy_o=1 in cycles 1-4, s_ma_result_o=0x12345678 valid at cycle 5.
- **Finish under stall:** finish in WAIT while s_stall_i=1 for 3 cycles, result 0xDEAD_BEEF → DONE entered, s_ma_valid_o/s_ma_result_o unchanged while stalled, 0xDEADBEEF valid one cycle after stall release.
- **Watchdog:** TIMEOUT=8, s_multi_i=1, never finish → s_timeout_o single pulse 8 cycles after WAIT entry, state IDLE, s_ma_valid_o=0, hold released.
- **Flush in WAIT coincident with finish:** s_flush_i=1 and s_finished_i=1 same cycle → no capture, s_ma_valid_o=0, state IDLE, s_timeout_o=0.
- **Reset mid-DONE:** s_reset_i asserted while buffer holds 0xCAFE_0001 → after the edge all outputs 0; a later stall release produces no result.
